fetch_unit: RTL and testbench

//  Instruction-fetch stage of the RV32 core. It holds the PC, issues word requests to instruction

---
 rtl/rv_core_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_core_pkg.sv
// Shared RV32 core definitions: datapath widths, reset PC and the fetch-buffer entry type.
package rv_core_pkg;

  localparam int              XLEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam int              INST_W   = 32;
  localparam int              OPCODE_W = 7;

  // One buffered fetch result: instruction word and the address it came from
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   pc;
  } fetch_entry_t;

  // Major opcode field that decode uses to drive the control unit
  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INST_W-1:0] i_inst);
    return i_inst[OPCODE_W-1:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; pointers and count reset asynchronously, storage is not reset.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // A flush discards everything, so it also cancels a same-cycle push or pop
  assign w_pop  = i_pop && !o_empty && !i_flush;
  assign w_push = i_push && (!o_full || w_pop) && !i_flush;

  // Storage write; contents are qualified by the count, so no reset is needed
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping, flush has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32 instruction fetch: PC, credit-limited imem requests, stale-response dropping
// after redirects, and an in-order {inst, pc} buffer toward decode.
module fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = rv_core_pkg::RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc
);

  import rv_core_pkg::*;

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam int          CW      = AW + 1;
  localparam int          EW      = INST_W + XLEN;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_inflight;
  logic [CW-1:0]   r_drop;
  logic [XLEN-1:0] r_pcq [FIFO_DEPTH];
  logic [AW-1:0]   r_pcq_wr;
  logic [AW-1:0]   r_pcq_rd;

  logic            w_req_fire;
  logic            w_rsp_keep;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic [CW-1:0]   w_fifo_count;
  logic [CW:0]     w_credit_used;
  logic [EW-1:0]   w_fifo_wdata;
  logic [EW-1:0]   w_fifo_rdata;
  logic [XLEN-1:0] w_redirect_tgt;

  assign w_redirect_tgt = redirect_pc & ~XLEN'(3);

  // Outstanding requests (including ones marked for dropping) plus buffered entries
  // may never exceed the buffer size, so every response has a slot waiting for it.
  assign w_credit_used  = {1'b0, r_inflight} + {1'b0, w_fifo_count};
  assign imem_req_valid = rst_n && !redirect_valid && (w_credit_used < DEPTH_C);
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // Responses are kept only when nothing stale is still ahead of them
  assign w_rsp_keep   = imem_rsp_valid && (r_drop == '0) && !redirect_valid;
  assign w_fifo_wdata = {imem_rsp_data, r_pcq[r_pcq_rd]};

  // Zero the outputs while empty so stale storage never leaks toward decode
  assign inst_valid = !w_fifo_empty;
  assign inst       = w_fifo_empty ? '0 : w_fifo_rdata[EW-1:XLEN];
  assign inst_pc    = w_fifo_empty ? '0 : w_fifo_rdata[XLEN-1:0];

  // Program counter: redirect wins, otherwise advance by one word per accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= w_redirect_tgt;
    end else if (w_req_fire) begin
      r_pc <= r_pc + XLEN'(4);
    end
  end

  // In-flight and drop counters; on redirect everything still outstanding becomes stale
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
      r_drop     <= '0;
    end else begin
      r_inflight <= r_inflight + CW'(w_req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        r_drop <= r_inflight - CW'(imem_rsp_valid);
      end else if (imem_rsp_valid && (r_drop != '0)) begin
        r_drop <= r_drop - CW'(1);
      end
    end
  end

  // Issued-address queue storage: one entry per request, consumed by its response
  always_ff @(posedge clk) begin
    if (w_req_fire) r_pcq[r_pcq_wr] <= r_pc;
  end

  // Issued-address queue pointers; not flushed by redirect because stale responses still consume entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcq_wr <= '0;
      r_pcq_rd <= '0;
    end else begin
      if (w_req_fire)     r_pcq_wr <= r_pcq_wr + AW'(1);
      if (imem_rsp_valid) r_pcq_rd <= r_pcq_rd + AW'(1);
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_rsp_keep),
    .i_data  (w_fifo_wdata),
    .i_pop   (inst_ready),
    .i_flush (redirect_valid),
    .o_data  (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // A response must always answer an outstanding request
  a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (r_inflight != '0));

  // Credits guarantee a kept response never meets a full buffer
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    w_rsp_keep |-> !w_fifo_full);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: imem model with random latency, sequential-PC
// reference model, directed scenarios, randomized traffic with a mid-run reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;

  logic        b_req_valid, b_req_ready;
  logic [31:0] b_req_addr;
  logic        b_rsp_valid;
  logic [31:0] b_rsp_data;
  logic        b_redirect_valid;
  logic [31:0] b_redirect_pc;
  logic        b_inst_valid, b_inst_ready;
  logic [31:0] b_inst, b_inst_pc;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(b_req_valid), .imem_req_ready(b_req_ready), .imem_req_addr(b_req_addr),
    .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(b_rsp_data),
    .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
    .inst_valid(b_inst_valid), .inst_ready(b_inst_ready), .inst(b_inst), .inst_pc(b_inst_pc)
  );

  always #5 clk = ~clk;

  int eg = 0;
  always @(posedge clk) eg <= eg + 1;

  typedef struct { logic [31:0] addr; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

  req_t        pend[$];
  exp_t        exp_q[$];
  logic [31:0] b_addrs[$];
  logic [31:0] exp_next, req_exp_pc, b_exp_pc, prev_addr;
  logic        prev_stall;
  int          last_due, b_pend, n_fire, n_pop;
  int          n_tests = 0, n_fail = 0;
  bit          rnd = 0;
  int          fix_lat = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] r;
    r = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard / imem request capture, sampled mid-cycle
  always @(negedge clk) begin : mon
    exp_t        e;
    logic [31:0] tgt;
    int          lat, due;
    if (rst_n) begin
      while (exp_q.size() < 8) begin
        exp_q.push_back('{exp_next, mem_word(exp_next)});
        exp_next += 32'd4;
      end
      if (prev_stall && !redirect_valid) begin
        check("req_hold_valid", {31'b0, imem_req_valid}, 32'd1);
        check("req_hold_addr", imem_req_addr, prev_addr);
      end
      prev_stall = imem_req_valid && !imem_req_ready;
      prev_addr  = imem_req_addr;
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, req_exp_pc);
        req_exp_pc += 32'd4;
        n_fire++;
        lat = rnd ? int'($urandom_range(1, 4)) : fix_lat;
        due = eg + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend.push_back('{imem_req_addr, due});
      end
      if (redirect_valid) begin
        check("redir_req_off", {31'b0, imem_req_valid}, 32'd0);
        tgt        = redirect_pc & ~32'h3;
        req_exp_pc = tgt;
        exp_next   = tgt;
        exp_q.delete();
      end else if (inst_valid && inst_ready) begin
        e = exp_q.pop_front();
        check("inst_pc", inst_pc, e.pc);
        check("inst_data", inst, e.data);
        n_pop++;
      end
      if (b_req_valid && b_req_ready) begin
        b_pend++;
        if (b_addrs.size() < 3) b_addrs.push_back(b_req_addr);
      end
      if (b_inst_valid && b_inst_ready) begin
        check("b_inst_pc", b_inst_pc, b_exp_pc);
        check("b_inst", b_inst, 32'd0);
        b_exp_pc += 32'd4;
      end
    end
  end

  task automatic cycle();
    @(posedge clk); #2;
    if (pend.size() > 0 && pend[0].due <= eg) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
      pend.delete(0);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    if (b_pend > 0) begin
      b_rsp_valid = 1'b1;
      b_pend--;
    end else begin
      b_rsp_valid = 1'b0;
    end
    if (rnd) begin
      imem_req_ready = ($urandom_range(0, 9) < 7);
      inst_ready     = ($urandom_range(0, 9) < 6);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
    end else begin
      redirect_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n          = 1'b0;
    imem_rsp_valid = 1'b0;
    b_rsp_valid    = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    pend.delete();
    exp_q.delete();
    exp_next   = 32'h0;
    req_exp_pc = 32'h0;
    b_exp_pc   = 32'hFFFF_FFF8;
    prev_stall = 1'b0;
    last_due   = -1;
    b_pend     = 0;
    n_fire     = 0;
    n_pop      = 0;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int  p0;
    bit  found;
    imem_req_ready   = 1'b1;
    imem_rsp_valid   = 1'b0;
    imem_rsp_data    = 32'h0;
    redirect_valid   = 1'b0;
    redirect_pc      = 32'h0;
    inst_ready       = 1'b1;
    b_req_ready      = 1'b1;
    b_rsp_valid      = 1'b0;
    b_rsp_data       = 32'h0;
    b_redirect_valid = 1'b0;
    b_redirect_pc    = 32'h0;
    b_inst_ready     = 1'b1;

    // Streaming from reset with 1-cycle imem
    fix_lat = 1;
    do_reset();
    repeat (30) cycle();
    check("t1_stream_pops", 32'(n_pop >= 15), 32'd1);
    check("t5_addr_count", 32'(b_addrs.size()), 32'd3);
    if (b_addrs.size() == 3) begin
      check("t5_addr0", b_addrs[0], 32'hFFFF_FFF8);
      check("t5_addr1", b_addrs[1], 32'hFFFF_FFFC);
      check("t5_addr2", b_addrs[2], 32'h0000_0000);
    end

    // Decode stalled: buffer fills, credits exhaust, pc parks at 8
    inst_ready = 1'b0;
    do_reset();
    repeat (10) cycle();
    check("t2_fires", 32'(n_fire), 32'd2);
    check("t2_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("t2_pc", imem_req_addr, 32'h8);
    inst_ready = 1'b1;
    repeat (20) cycle();
    check("t2_resume_pops", 32'(n_pop >= 6), 32'd1);

    // Redirect with two requests in flight on a 3-cycle imem
    fix_lat = 3;
    do_reset();
    cycle();
    cycle();
    check("t3_inflight", 32'(pend.size()), 32'd2);
    check("t3_req_blocked", {31'b0, imem_req_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    cycle();
    p0 = n_pop;
    repeat (20) cycle();
    check("t3_pops_after", 32'(n_pop > p0), 32'd1);

    // Redirect coinciding with a response and a pop
    fix_lat = 1;
    do_reset();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (imem_rsp_valid && inst_valid) found = 1;
    end
    check("t4_found_slot", {31'b0, found}, 32'd1);
    if (found) begin
      redirect_valid = 1'b1;
      redirect_pc    = 32'h203;
      cycle();
      check("t4_fifo_empty", {31'b0, inst_valid}, 32'd0);
      check("t4_next_addr", imem_req_addr, 32'h200);
    end
    repeat (10) cycle();

    // Randomized traffic with a mid-run reset
    rnd = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      cycle();
    end

    // Drain: no redirects, everything ready, stream must keep flowing
    rnd            = 0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    fix_lat        = 2;
    p0             = n_pop;
    repeat (40) cycle();
    check("drain_progress", 32'(n_pop - p0 >= 10), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
